// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer: drives one butterfly unit through a full in-place
// forward (Cooley-Tukey) or inverse (Gentleman-Sande) NTT over one RAM.
// Read addresses, twiddle index and mode are generated per butterfly; the
// addresses are replayed to the write port after the butterfly latency.
// Optional feature macro: NTT_SEQ_PERF_EN (adds the cycle_cnt output).
module ntt_stage_sequencer #(
  parameter int LOGN_MAX = 13,
  parameter int LAT_CT   = 17,
  parameter int LAT_GS   = 19,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                inverse,
  input  logic [3:0]          logn,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic                use_ct,
  output logic                rd_en,
  output logic [LOGN_MAX-1:0] rd_addr_a,
  output logic [LOGN_MAX-1:0] rd_addr_b,
  output logic [LOGN_MAX-1:0] tw_idx,
  output logic                wr_en,
  output logic [LOGN_MAX-1:0] wr_addr_a,
  output logic [LOGN_MAX-1:0] wr_addr_b
`ifdef NTT_SEQ_PERF_EN
  ,
  output logic [31:0]         cycle_cnt
`endif
);

  // Total read-to-write distance per mode and the longest pipeline needed.
  localparam int L_CT  = RD_LAT + LAT_CT;
  localparam int L_GS  = RD_LAT + LAT_GS;
  localparam int DEPTH = (L_CT > L_GS) ? L_CT : L_GS;
  localparam int CW    = $clog2(DEPTH + 1);
  // DRAIN is entered on the edge that registers the last issue, so the
  // count starts one below L to land the next issue exactly L cycles later.
  localparam logic [CW-1:0]       CNT_CT = CW'(L_CT - 1);
  localparam logic [CW-1:0]       CNT_GS = CW'(L_GS - 1);
  localparam logic [LOGN_MAX-1:0] ONE    = LOGN_MAX'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          s_reg, s_next;
  logic [3:0]          logn_reg, logn_next;
  logic [LOGN_MAX-1:0] j_reg, j_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                use_ct_reg, use_ct_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                rd_en_reg, rd_en_next;
  logic [LOGN_MAX-1:0] rd_a_reg, rd_a_next;
  logic [LOGN_MAX-1:0] rd_b_reg, rd_b_next;
  logic [LOGN_MAX-1:0] tw_reg, tw_next;

  // Address arithmetic for the current (s, j)
  logic [3:0]          sh, tw_sh;
  logic [LOGN_MAX-1:0] len, grp, off, addr_a, addr_b, tw_calc, half_m1;

  // Write-side replay pipeline of {valid, a, b}
  logic                pipe_v [DEPTH];
  logic [LOGN_MAX-1:0] pipe_a [DEPTH];
  logic [LOGN_MAX-1:0] pipe_b [DEPTH];

  // Butterfly index decomposition; CT and GS differ only in which shift
  // sets the block length and which one sets the twiddle base.
  always_comb begin
    sh      = use_ct_reg ? (logn_reg - 4'd1 - s_reg) : s_reg;
    tw_sh   = use_ct_reg ? s_reg : (logn_reg - 4'd1 - s_reg);
    len     = ONE << sh;
    grp     = j_reg >> sh;
    off     = j_reg & (len - ONE);
    addr_a  = (grp << (sh + 4'd1)) | off;
    addr_b  = addr_a | len;
    tw_calc = (ONE << tw_sh) + grp;
    half_m1 = (ONE << (logn_reg - 4'd1)) - ONE;
  end

  // Next-state and registered-output decode
  always_comb begin
    state_next  = state_reg;
    s_next      = s_reg;
    logn_next   = logn_reg;
    j_next      = j_reg;
    cnt_next    = cnt_reg;
    use_ct_next = use_ct_reg;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    rd_en_next  = 1'b0;
    rd_a_next   = rd_a_reg;
    rd_b_next   = rd_b_reg;
    tw_next     = tw_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          use_ct_next = ~inverse;
          logn_next   = logn;
          s_next      = 4'd0;
          j_next      = '0;
          state_next  = (logn == 4'd0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        busy_next = 1'b1;
        if (!hold) begin
          rd_en_next = 1'b1;
          rd_a_next  = addr_a;
          rd_b_next  = addr_b;
          tw_next    = tw_calc;
          if (j_reg == half_m1) begin
            state_next = DRAIN;
            cnt_next   = use_ct_reg ? CNT_CT : CNT_GS;
          end else begin
            j_next = j_reg + ONE;
          end
        end
      end
      DRAIN: begin
        busy_next = 1'b1;
        if (cnt_reg == '0) begin
          if (s_reg == logn_reg - 4'd1) begin
            state_next = FINISH;
          end else begin
            s_next     = s_reg + 4'd1;
            j_next     = '0;
            state_next = ISSUE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      FINISH: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      s_reg      <= 4'd0;
      logn_reg   <= 4'd0;
      j_reg      <= '0;
      cnt_reg    <= '0;
      use_ct_reg <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      rd_en_reg  <= 1'b0;
      rd_a_reg   <= '0;
      rd_b_reg   <= '0;
      tw_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      s_reg      <= s_next;
      logn_reg   <= logn_next;
      j_reg      <= j_next;
      cnt_reg    <= cnt_next;
      use_ct_reg <= use_ct_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      rd_en_reg  <= rd_en_next;
      rd_a_reg   <= rd_a_next;
      rd_b_reg   <= rd_b_next;
      tw_reg     <= tw_next;
    end
  end

  // Replay pipeline: stage k holds the read issued k+1 cycles ago
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe_v[k] <= 1'b0;
        pipe_a[k] <= '0;
        pipe_b[k] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_en_reg;
      pipe_a[0] <= rd_a_reg;
      pipe_b[0] <= rd_b_reg;
      for (int k = 1; k < DEPTH; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_a[k] <= pipe_a[k-1];
        pipe_b[k] <= pipe_b[k-1];
      end
    end
  end

`ifdef NTT_SEQ_PERF_EN
  // Busy-cycle counter, cleared on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= 32'd0;
    end else if (state_reg == IDLE && start) begin
      cycle_cnt <= 32'd0;
    end else if (busy_next) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign use_ct    = use_ct_reg;
  assign rd_en     = rd_en_reg;
  assign rd_addr_a = rd_a_reg;
  assign rd_addr_b = rd_b_reg;
  assign tw_idx    = tw_reg;
  // Mode is fixed for the whole operation, so the tap never switches mid-run.
  assign wr_en     = use_ct_reg ? pipe_v[L_CT-1] : pipe_v[L_GS-1];
  assign wr_addr_a = use_ct_reg ? pipe_a[L_CT-1] : pipe_a[L_GS-1];
  assign wr_addr_b = use_ct_reg ? pipe_b[L_CT-1] : pipe_b[L_GS-1];

endmodule
